// File: rtl/laser_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : laser_frame_sched
// Brief    : Run controller for the laser pulse datapath. Generates the shared
//            phase counter, pulse width and BG/A/B frame type for a programmed
//            number of frames, with configuration shadowed at frame boundaries.
//            Optional status ports (frame_idx, upd_pending) are enabled by
//            defining LASER_SCHED_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module laser_frame_sched #(
    parameter int CNT_WIDTH = 32,
    parameter int FRM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_width,
    input  logic [FRM_WIDTH-1:0] cfg_pulses,
    input  logic [FRM_WIDTH-1:0] cfg_frames,
    input  logic                 cfg_bg_en,
    input  logic                 cfg_update,
    output logic [CNT_WIDTH-1:0] laser_cnt_out,
    output logic [CNT_WIDTH-1:0] laser_width_out,
    output logic [1:0]           frame_type,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 run_done,
    output logic                 busy
`ifdef LASER_SCHED_STATUS_EN
    ,
    output logic [FRM_WIDTH-1:0] frame_idx,
    output logic                 upd_pending
`endif
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_RUN      = 2'd1;
    localparam logic [1:0] c_STOPPING = 2'd2;

    localparam logic [1:0] c_FT_BG = 2'b00;
    localparam logic [1:0] c_FT_A  = 2'b01;
    localparam logic [1:0] c_FT_B  = 2'b10;

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [FRM_WIDTH-1:0] r_pidx;
    logic [FRM_WIDTH-1:0] r_fcnt;
    logic [1:0]           r_type;
    logic                 r_pend;
    logic                 r_frame_start;
    logic                 r_frame_done;
    logic                 r_run_done;
    logic                 r_busy;

    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_width;
    logic [FRM_WIDTH-1:0] r_pulses;
    logic [FRM_WIDTH-1:0] r_frames;
    logic                 r_bg_en;

    logic [1:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [FRM_WIDTH-1:0] w_pidx_nxt;
    logic [FRM_WIDTH-1:0] w_fcnt_nxt;
    logic [1:0]           w_type_nxt;
    logic                 w_pend_nxt;
    logic                 w_load;
    logic                 w_bg_sel;
    logic                 w_fstart_nxt;
    logic                 w_fdone_nxt;
    logic                 w_rdone_nxt;
    logic [CNT_WIDTH-1:0] w_per_m1;
    logic [FRM_WIDTH-1:0] w_pul_m1;
    logic [FRM_WIDTH:0]   w_fcnt_p1;

    // Clamped terminal values of the current shadow configuration.
    assign w_per_m1 = ((r_period < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : r_period) - CNT_WIDTH'(1);
    assign w_pul_m1 = (r_pulses == '0) ? '0 : (r_pulses - FRM_WIDTH'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pidx_nxt   = r_pidx;
        w_fcnt_nxt   = r_fcnt;
        w_type_nxt   = r_type;
        w_pend_nxt   = r_pend;
        w_load       = 1'b0;
        w_bg_sel     = r_bg_en;
        w_fstart_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt  = c_RUN;
                    w_load       = 1'b1;
                    w_cnt_nxt    = '0;
                    w_pidx_nxt   = '0;
                    w_fcnt_nxt   = '0;
                    w_pend_nxt   = 1'b0;
                    w_type_nxt   = cfg_bg_en ? c_FT_BG : c_FT_A;
                    w_fstart_nxt = 1'b1;
                end
            end
            c_RUN, c_STOPPING: begin
                if (r_state == c_RUN && stop) begin
                    w_state_nxt = c_STOPPING;
                end
                if (cfg_update) begin
                    w_pend_nxt = 1'b1;
                end
                if (r_frame_done) begin
                    w_fcnt_nxt = r_fcnt + FRM_WIDTH'(1);
                    w_cnt_nxt  = '0;
                    w_pidx_nxt = '0;
                    if (r_run_done) begin
                        w_state_nxt = c_IDLE;
                        w_type_nxt  = c_FT_BG;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_fstart_nxt = 1'b1;
                        if (r_pend || cfg_update) begin
                            w_load     = 1'b1;
                            w_pend_nxt = 1'b0;
                            w_bg_sel   = cfg_bg_en;
                        end
                        case (r_type)
                            c_FT_BG: w_type_nxt = c_FT_A;
                            c_FT_A:  w_type_nxt = c_FT_B;
                            default: w_type_nxt = w_bg_sel ? c_FT_BG : c_FT_A;
                        endcase
                    end
                end else if (r_cnt == w_per_m1) begin
                    w_cnt_nxt  = '0;
                    w_pidx_nxt = r_pidx + FRM_WIDTH'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
                w_type_nxt  = c_FT_BG;
            end
        endcase
    end

    // Frame/run completion are looked ahead one cycle so they can be registered.
    // A frame's first cycle never terminates it (period >= 2), so the old
    // shadow values are safe to use across a reload boundary.
    always_comb begin
        w_fcnt_p1   = {1'b0, w_fcnt_nxt} + (FRM_WIDTH+1)'(1);
        w_fdone_nxt = (w_state_nxt != c_IDLE) && (w_cnt_nxt == w_per_m1) &&
                      (w_pidx_nxt == w_pul_m1);
        w_rdone_nxt = w_fdone_nxt &&
                      ((w_state_nxt == c_STOPPING) ||
                       ((r_frames != '0) && (w_fcnt_p1 >= {1'b0, r_frames})));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_pidx        <= '0;
            r_fcnt        <= '0;
            r_type        <= c_FT_BG;
            r_pend        <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_run_done    <= 1'b0;
            r_busy        <= 1'b0;
            r_period      <= '0;
            r_width       <= '0;
            r_pulses      <= '0;
            r_frames      <= '0;
            r_bg_en       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pidx        <= w_pidx_nxt;
            r_fcnt        <= w_fcnt_nxt;
            r_type        <= w_type_nxt;
            r_pend        <= w_pend_nxt;
            r_frame_start <= w_fstart_nxt;
            r_frame_done  <= w_fdone_nxt;
            r_run_done    <= w_rdone_nxt;
            r_busy        <= (w_state_nxt != c_IDLE);
            if (w_load) begin
                r_period <= cfg_period;
                r_width  <= cfg_width;
                r_pulses <= cfg_pulses;
                r_frames <= cfg_frames;
                r_bg_en  <= cfg_bg_en;
            end
        end
    end

    assign laser_cnt_out   = r_cnt;
    assign laser_width_out = r_width;
    assign frame_type      = r_type;
    assign frame_start     = r_frame_start;
    assign frame_done      = r_frame_done;
    assign run_done        = r_run_done;
    assign busy            = r_busy;
`ifdef LASER_SCHED_STATUS_EN
    assign frame_idx       = r_fcnt;
    assign upd_pending     = r_pend;
`endif

endmodule
`default_nettype wire

// File: tb/tb_laser_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_laser_frame_sched
// Brief    : Scoreboard bench for laser_frame_sched; directed runs push the
//            expected frame events, a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_laser_frame_sched;

    localparam int CW = 32;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] cfg_period = '0;
    logic [CW-1:0] cfg_width = '0;
    logic [FW-1:0] cfg_pulses = '0;
    logic [FW-1:0] cfg_frames = '0;
    logic          cfg_bg_en = 1'b0;
    logic          cfg_update = 1'b0;
    logic [CW-1:0] laser_cnt_out;
    logic [CW-1:0] laser_width_out;
    logic [1:0]    frame_type;
    logic          frame_start;
    logic          frame_done;
    logic          run_done;
    logic          busy;
`ifdef LASER_SCHED_STATUS_EN
    logic [FW-1:0] frame_idx;
    logic          upd_pending;
`endif

    laser_frame_sched #(.CNT_WIDTH(CW), .FRM_WIDTH(FW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .cfg_period      (cfg_period),
        .cfg_width       (cfg_width),
        .cfg_pulses      (cfg_pulses),
        .cfg_frames      (cfg_frames),
        .cfg_bg_en       (cfg_bg_en),
        .cfg_update      (cfg_update),
        .laser_cnt_out   (laser_cnt_out),
        .laser_width_out (laser_width_out),
        .frame_type      (frame_type),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .run_done        (run_done),
        .busy            (busy)
`ifdef LASER_SCHED_STATUS_EN
        ,
        .frame_idx       (frame_idx),
        .upd_pending     (upd_pending)
`endif
    );

    typedef struct {
        int          cyc;
        logic [2:0]  flags;   // {frame_start, frame_done, run_done}
        logic [1:0]  ty;
        logic [31:0] cnt;
    } ev_t;

    ev_t exq[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input int c, input logic [2:0] f,
                                      input logic [1:0] t, input logic [31:0] n);
        ev_t e;
        e.cyc = c; e.flags = f; e.ty = t; e.cnt = n;
        exq.push_back(e);
    endfunction

    // Monitor: every cycle the DUT presents a frame event, pop and compare.
    always @(negedge clk) begin
        if (frame_start || frame_done || run_done) begin
            if (exq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got fs=%0b fd=%0b rd=%0b expected none (cycle %0d)",
                         frame_start, frame_done, run_done, cyc);
            end else begin
                ev_t e;
                e = exq.pop_front();
                chk("ev_cycle", 64'(cyc), 64'(e.cyc));
                chk("ev_flags", {61'd0, frame_start, frame_done, run_done}, {61'd0, e.flags});
                chk("ev_type", {62'd0, frame_type}, {62'd0, e.ty});
                chk("ev_cnt", {32'd0, laser_cnt_out}, {32'd0, e.cnt});
                chk("ev_busy", {63'd0, busy}, 64'd1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic set_cfg(input logic [CW-1:0] p, input logic [CW-1:0] w,
                           input logic [FW-1:0] pu, input logic [FW-1:0] fr, input logic bg);
        cfg_period = p; cfg_width = w; cfg_pulses = pu; cfg_frames = fr; cfg_bg_en = bg;
    endtask

    task automatic pulse_start(input logic with_stop);
        start = 1'b1;
        stop  = with_stop;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic end_check(input int t_idle, input string tag);
        go_to(t_idle);
        chk({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
        chk({tag, "_cnt_idle"}, {32'd0, laser_cnt_out}, 64'd0);
        chk({tag, "_type_idle"}, {62'd0, frame_type}, 64'd0);
        chk({tag, "_queue_drained"}, 64'(exq.size()), 64'd0);
    endtask

    initial begin
        int t;

        // Reset state
        step(3);
        chk("rst_cnt", {32'd0, laser_cnt_out}, 64'd0);
        chk("rst_width", {32'd0, laser_width_out}, 64'd0);
        chk("rst_type", {62'd0, frame_type}, 64'd0);
        chk("rst_pulses", {61'd0, frame_start, frame_done, run_done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        step(2);

        // Basic run: BG, A, B of 8 cycles each
        set_cfg(4, 2, 2, 3, 1'b1);
        t = cyc;
        expect_ev(t+1,  3'b100, 2'b00, 0);
        expect_ev(t+8,  3'b010, 2'b00, 3);
        expect_ev(t+9,  3'b100, 2'b01, 0);
        expect_ev(t+16, 3'b010, 2'b01, 3);
        expect_ev(t+17, 3'b100, 2'b10, 0);
        expect_ev(t+24, 3'b011, 2'b10, 3);
        pulse_start(1'b0);
        chk("basic_busy_start", {63'd0, busy}, 64'd1);
        for (int k = 1; k <= 8; k++) begin
            go_to(t + k);
            chk("basic_cnt_seq", {32'd0, laser_cnt_out}, 64'((k - 1) % 4));
        end
        chk("basic_width", {32'd0, laser_width_out}, 64'd2);
        end_check(t + 25, "basic");

        // Continuous A/B without BG, ended by stop
        set_cfg(4, 1, 1, 0, 1'b0);
        t = cyc;
        expect_ev(t+1,  3'b100, 2'b01, 0);
        expect_ev(t+4,  3'b010, 2'b01, 3);
        expect_ev(t+5,  3'b100, 2'b10, 0);
        expect_ev(t+8,  3'b010, 2'b10, 3);
        expect_ev(t+9,  3'b100, 2'b01, 0);
        expect_ev(t+12, 3'b010, 2'b01, 3);
        expect_ev(t+13, 3'b100, 2'b10, 0);
        expect_ev(t+16, 3'b011, 2'b10, 3);
        pulse_start(1'b0);
        go_to(t + 14);
        stop = 1'b1; step(1); stop = 1'b0;
        end_check(t + 17, "nobg");

        // Stop mid-run; a start while stopping is ignored
        set_cfg(4, 2, 2, 0, 1'b1);
        t = cyc;
        expect_ev(t+1,  3'b100, 2'b00, 0);
        expect_ev(t+8,  3'b010, 2'b00, 3);
        expect_ev(t+9,  3'b100, 2'b01, 0);
        expect_ev(t+16, 3'b011, 2'b01, 3);
        pulse_start(1'b0);
        go_to(t + 10);
        stop = 1'b1; step(1); stop = 1'b0;
        go_to(t + 12);
        start = 1'b1; step(1); start = 1'b0;
        end_check(t + 17, "stop");

        // Deferred update: period 8 takes effect at the A frame
        set_cfg(4, 2, 2, 3, 1'b1);
        t = cyc;
        expect_ev(t+1,  3'b100, 2'b00, 0);
        expect_ev(t+8,  3'b010, 2'b00, 3);
        expect_ev(t+9,  3'b100, 2'b01, 0);
        expect_ev(t+24, 3'b010, 2'b01, 7);
        expect_ev(t+25, 3'b100, 2'b10, 0);
        expect_ev(t+40, 3'b011, 2'b10, 7);
        pulse_start(1'b0);
        go_to(t + 3);
        cfg_period = 8; cfg_update = 1'b1; step(1); cfg_update = 1'b0;
        go_to(t + 5);
        chk("upd_first_frame_cnt", {32'd0, laser_cnt_out}, 64'd0);
        end_check(t + 41, "update");

        // Clamping: period 0 and pulses 0 give 2-cycle frames
        set_cfg(0, 1, 0, 2, 1'b1);
        t = cyc;
        expect_ev(t+1, 3'b100, 2'b00, 0);
        expect_ev(t+2, 3'b010, 2'b00, 1);
        expect_ev(t+3, 3'b100, 2'b01, 0);
        expect_ev(t+4, 3'b011, 2'b01, 1);
        pulse_start(1'b0);
        end_check(t + 5, "clamp");

        // start and stop together in IDLE: start wins, full run
        set_cfg(4, 1, 1, 2, 1'b0);
        t = cyc;
        expect_ev(t+1, 3'b100, 2'b01, 0);
        expect_ev(t+4, 3'b010, 2'b01, 3);
        expect_ev(t+5, 3'b100, 2'b10, 0);
        expect_ev(t+8, 3'b011, 2'b10, 3);
        pulse_start(1'b1);
        end_check(t + 9, "startstop");

        // Reset mid-run: reset values next cycle, no further events
        set_cfg(4, 2, 2, 3, 1'b1);
        t = cyc;
        expect_ev(t+1, 3'b100, 2'b00, 0);
        pulse_start(1'b0);
        go_to(t + 5);
        rst = 1'b1; step(1);
        chk("midrst_cnt", {32'd0, laser_cnt_out}, 64'd0);
        chk("midrst_width", {32'd0, laser_width_out}, 64'd0);
        chk("midrst_type", {62'd0, frame_type}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        end_check(t + 30, "midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
